// File: rtl/memory_controller.sv
// memory_controller: serves L1 requests from a word-addressed RAM after LATENCY cycles.
// Optional MEMORY_CONTROLLER_FAST_WRITE_EN commits valid writes at the capture edge.
module memory_controller #(
    parameter int MEMORY_WORDS = 1024,
    parameter int LATENCY      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] input_data,
    input  logic        should_write,
    output logic [31:0] output_data,
    output logic        ready,
    output logic        fault
);
    localparam int AW = $clog2(MEMORY_WORDS);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pend_addr_q, pend_addr_d, pend_data_q, pend_data_d;
    logic        pend_write_q, pend_write_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] last_addr_q, last_addr_d, last_data_q, last_data_d;
    logic        last_write_q, last_write_d, last_valid_q, last_valid_d;
    logic [31:0] out_q, out_d;
    logic        fault_q, fault_d;
    logic [31:0] mem [MEMORY_WORDS] = '{default: '0};

    logic          match, differ, fast, commit, c_write, c_bad;
    logic [31:0]   c_addr, c_data;
    logic [AW-1:0] c_idx;

    assign match  = last_valid_q && address == last_addr_q && should_write == last_write_q &&
                    (!should_write || input_data == last_data_q);
    assign differ = address != pend_addr_q || should_write != pend_write_q ||
                    (should_write && input_data != pend_data_q);
`ifdef MEMORY_CONTROLLER_FAST_WRITE_EN
    logic in_bad;
    assign in_bad = address[1:0] != 2'b0 || {2'b0, address[31:2]} >= 32'(MEMORY_WORDS);
    assign fast   = state_q == IDLE && !match && should_write && !in_bad;
`else
    assign fast   = 1'b0;
`endif
    // A fast write commits straight from the port tuple instead of the pending copy.
    assign commit  = fast || (state_q == WAIT && !differ && cnt_q == 8'd0);
    assign c_addr  = fast ? address : pend_addr_q;
    assign c_write = fast ? 1'b1 : pend_write_q;
    assign c_data  = fast ? input_data : pend_data_q;
    assign c_bad   = c_addr[1:0] != 2'b0 || {2'b0, c_addr[31:2]} >= 32'(MEMORY_WORDS);
    assign c_idx   = c_addr[AW+1:2];

    always_comb begin
        state_d      = state_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        pend_write_d = pend_write_q;
        cnt_d        = cnt_q;
        last_addr_d  = last_addr_q;
        last_data_d  = last_data_q;
        last_write_d = last_write_q;
        last_valid_d = last_valid_q;
        out_d        = out_q;
        fault_d      = fault_q;
        if (commit) begin
            state_d      = IDLE;
            last_addr_d  = c_addr;
            last_data_d  = c_data;
            last_write_d = c_write;
            last_valid_d = 1'b1;
            out_d        = c_bad ? 32'd0 : c_write ? c_data : mem[c_idx];
            fault_d      = c_bad;
        end else if ((state_q == IDLE && !match) || (state_q == WAIT && differ)) begin
            state_d      = WAIT;
            pend_addr_d  = address;
            pend_data_d  = input_data;
            pend_write_d = should_write;
            cnt_d        = 8'(LATENCY - 1);
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            pend_write_q <= 1'b0;
            cnt_q        <= '0;
            last_addr_q  <= '0;
            last_data_q  <= '0;
            last_write_q <= 1'b0;
            last_valid_q <= 1'b0;
            out_q        <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            pend_write_q <= pend_write_d;
            cnt_q        <= cnt_d;
            last_addr_q  <= last_addr_d;
            last_data_q  <= last_data_d;
            last_write_q <= last_write_d;
            last_valid_q <= last_valid_d;
            out_q        <= out_d;
            fault_q      <= fault_d;
        end
    end

    // RAM has no reset; the reset gate only stops a write landing while reset is held.
    always_ff @(posedge clock) begin
        if (!reset && commit && c_write && !c_bad)
            mem[c_idx] <= c_data;
    end

    assign ready       = state_q == IDLE && match;
    assign output_data = out_q;
    assign fault       = fault_q;
endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: directed and randomized checks against a request-level reference model.
module tb_memory_controller;
    localparam int LAT   = 4;
    localparam int WORDS = 1024;
`ifdef MEMORY_CONTROLLER_FAST_WRITE_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address = '0, input_data = '0;
    logic        should_write = 1'b0;
    logic [31:0] output_data;
    logic        ready, fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [WORDS];
    logic [31:0] la, ld, eo;
    logic        lw, lv, ef;

    memory_controller #(.MEMORY_WORDS(WORDS), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .address(address), .input_data(input_data),
        .should_write(should_write), .output_data(output_data), .ready(ready), .fault(fault)
    );

    always #5 clock = ~clock;

    function automatic logic is_bad(logic [31:0] a);
        return a[1:0] != 2'b0 || a[31:2] >= 30'(WORDS);
    endfunction

    function automatic int exp_lat(logic [31:0] a, logic w);
        return (FAST && w && !is_bad(a)) ? 1 : LAT + 1;
    endfunction

    task automatic model_commit(logic [31:0] a, logic w, logic [31:0] d);
        lv = 1'b1; la = a; lw = w; ld = d;
        if (is_bad(a)) begin
            eo = 32'd0; ef = 1'b1;
        end else begin
            ef = 1'b0;
            if (w) begin
                ref_mem[a[11:2]] = d;
                eo = d;
            end else eo = ref_mem[a[11:2]];
        end
    endtask

    task automatic issue(logic [31:0] a, logic w, logic [31:0] d);
        @(negedge clock);
        address = a; should_write = w; input_data = d;
        #1;
    endtask

    task automatic wait_ready(output int c);
        c = 0;
        while (!ready && c < 50) begin
            @(posedge clock);
            #1;
            c++;
        end
    endtask

    task automatic test_reset();
        @(posedge clock);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++; if (output_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", output_data); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fault); end
        lv = 1'b0; eo = 32'd0; ef = 1'b0;
    endtask

    task automatic test_read_zero();
        int c;
        @(negedge clock);
        reset = 1'b0; address = 32'h0; should_write = 1'b0; input_data = 32'h0;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL read0_present got %b exp 0", ready); end
        wait_ready(c);
        checks++; if (c !== LAT + 1) begin errors++; $display("FAIL read0_cycles got %0d exp %0d", c, LAT + 1); end
        checks++; if (output_data !== 32'd0) begin errors++; $display("FAIL read0_data got %h exp 0", output_data); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL read0_fault got %b exp 0", fault); end
        model_commit(32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_write_read();
        int c;
        issue(32'h10, 1'b1, 32'hCAFEBABE);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL wr_present got %b exp 0", ready); end
        wait_ready(c);
        checks++; if (c !== exp_lat(32'h10, 1'b1)) begin errors++; $display("FAIL wr_cycles got %0d exp %0d", c, exp_lat(32'h10, 1'b1)); end
        checks++; if (output_data !== 32'hCAFEBABE) begin errors++; $display("FAIL wr_echo got %h exp cafebabe", output_data); end
        model_commit(32'h10, 1'b1, 32'hCAFEBABE);
        issue(32'h10, 1'b0, 32'h0);
        wait_ready(c);
        checks++; if (c !== LAT + 1) begin errors++; $display("FAIL rd_cycles got %0d exp %0d", c, LAT + 1); end
        checks++; if (output_data !== 32'hCAFEBABE) begin errors++; $display("FAIL rd_data got %h exp cafebabe", output_data); end
        model_commit(32'h10, 1'b0, 32'h0);
    endtask

    task automatic test_zero_cost();
        int c;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checks++; if (ready !== 1'b1 || output_data !== eo) begin errors++; $display("FAIL hold_%0d got %b/%h exp 1/%h", i, ready, output_data, eo); end
        end
        issue(32'h10, 1'b0, 32'h1234);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL read_data_ignored got %b exp 1", ready); end
        issue(32'h14, 1'b0, 32'h0);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL comb_drop got %b exp 0", ready); end
        wait_ready(c);
        model_commit(32'h14, 1'b0, 32'h0);
        checks++; if (c !== LAT + 1 || output_data !== eo) begin errors++; $display("FAIL after_drop got %0d/%h exp %0d/%h", c, output_data, LAT + 1, eo); end
    endtask

    task automatic test_abort();
        int c;
        issue(32'h20, 1'b1, 32'hA5A5A5A5);
        @(posedge clock);
        @(posedge clock);
        issue(32'h24, 1'b1, 32'h5A5A5A5A);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL abort_present got %b exp 0", ready); end
        wait_ready(c);
        checks++; if (c !== LAT + 1) begin errors++; $display("FAIL abort_cycles got %0d exp %0d", c, LAT + 1); end
        checks++; if (output_data !== 32'h5A5A5A5A) begin errors++; $display("FAIL abort_echo got %h exp 5a5a5a5a", output_data); end
        model_commit(32'h24, 1'b1, 32'h5A5A5A5A);
        issue(32'h20, 1'b0, 32'h0);
        wait_ready(c);
        checks++; if (output_data !== 32'h0) begin errors++; $display("FAIL abort_unwritten got %h exp 0", output_data); end
        model_commit(32'h20, 1'b0, 32'h0);
        issue(32'h24, 1'b0, 32'h0);
        wait_ready(c);
        checks++; if (output_data !== 32'h5A5A5A5A) begin errors++; $display("FAIL abort_new got %h exp 5a5a5a5a", output_data); end
        model_commit(32'h24, 1'b0, 32'h0);
    endtask

    task automatic test_fault();
        int c;
        logic [31:0] bad_a [3];
        logic        bad_w [3];
        bad_a = '{32'h2, 32'(4 * WORDS), 32'h6};
        bad_w = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            issue(bad_a[i], bad_w[i], 32'hFFFF);
            wait_ready(c);
            checks++; if (c !== LAT + 1 || output_data !== 32'd0 || fault !== 1'b1) begin
                errors++; $display("FAIL fault_%0d got %0d/%h/%b exp %0d/0/1", i, c, output_data, fault, LAT + 1);
            end
            model_commit(bad_a[i], bad_w[i], 32'hFFFF);
        end
        issue(32'h10, 1'b0, 32'h0);
        wait_ready(c);
        checks++; if (fault !== 1'b0 || output_data !== 32'hCAFEBABE) begin errors++; $display("FAIL fault_clear got %b/%h exp 0/cafebabe", fault, output_data); end
        model_commit(32'h10, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_wait();
        int c;
        issue(32'h30, 1'b1, 32'h11111111);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (ready !== 1'b0 || output_data !== 32'd0) begin errors++; $display("FAIL rst_mid got %b/%h exp 0/0", ready, output_data); end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0; address = 32'h30; should_write = 1'b0;
        #1;
        lv = 1'b0;
        wait_ready(c);
        checks++; if (c !== LAT + 1 || output_data !== 32'd0) begin errors++; $display("FAIL rst_discard got %0d/%h exp %0d/0", c, output_data, LAT + 1); end
        model_commit(32'h30, 1'b0, 32'h0);
    endtask

    task automatic test_fast_write();
        int c;
        issue(32'h40, 1'b1, 32'h55);
        wait_ready(c);
        checks++; if (c !== exp_lat(32'h40, 1'b1) || output_data !== 32'h55) begin errors++; $display("FAIL fastwr got %0d/%h exp %0d/55", c, output_data, exp_lat(32'h40, 1'b1)); end
        model_commit(32'h40, 1'b1, 32'h55);
        issue(32'h40, 1'b0, 32'h0);
        wait_ready(c);
        checks++; if (c !== LAT + 1 || output_data !== 32'h55) begin errors++; $display("FAIL fastrd got %0d/%h exp %0d/55", c, output_data, LAT + 1); end
        model_commit(32'h40, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        int c, ec, r;
        logic [31:0] a, d;
        logic w, same;
        for (int i = 0; i < 30; i++) begin
            r = int'($urandom_range(0, 9));
            a = r == 0 ? 32'h100 + 4 * $urandom_range(0, 7) + $urandom_range(1, 3) :
                r == 1 ? 32'(4 * WORDS) + 4 * $urandom_range(0, 3) :
                         32'h100 + 4 * $urandom_range(0, 7);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if ($urandom_range(0, 4) == 0 && lv) begin a = la; w = lw; d = ld; end
            same = lv && a == la && w == lw && (!w || d == ld);
            ec = same ? 0 : exp_lat(a, w);
            issue(a, w, d);
            wait_ready(c);
            if (!same) model_commit(a, w, d);
            checks++; if (c !== ec) begin errors++; $display("FAIL rnd%0d_cycles a=%h w=%b got %0d exp %0d", i, a, w, c, ec); end
            checks++; if (output_data !== eo || fault !== ef) begin errors++; $display("FAIL rnd%0d_data a=%h w=%b got %h/%b exp %h/%b", i, a, w, output_data, fault, eo, ef); end
        end
    endtask

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = 32'd0;
        test_reset();
        test_read_zero();
        test_write_read();
        test_zero_cost();
`ifndef MEMORY_CONTROLLER_FAST_WRITE_EN
        test_abort();
        test_reset_mid_wait();
`endif
        test_fault();
        test_fast_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
